// File: rtl/icache_fill_ctrl_if.sv
// Hit-check, memory-adaptor and array-update signals of the icache line-fill controller.
// The master modport belongs to the controller and the slave modport to its environment.
// The early_valid/early_rdata pair exists only when ICACHE_FILL_EARLY_RESTART_EN is defined.
interface icache_fill_ctrl_if #(
   parameter int unsigned s_index  = 5,
   parameter int unsigned s_offset = 5
);
   localparam int unsigned s_tag = 32 - s_index - s_offset;

   // Hit-check stage side
   logic               miss_req;
   logic [31:0]        miss_addr;
   logic               miss_way;
   logic               busy;
   logic               fill_done;

   // Physical-memory adaptor side
   logic               burst_read;
   logic [31:0]        burst_addr;
   logic               burst_resp;
   logic [63:0]        burst_rdata;

   // Data/tag/valid/LRU array side
   logic               arr_load;
   logic               arr_way;
   logic [s_index-1:0] arr_windex;
   logic [255:0]       arr_line;
   logic [s_tag-1:0]   arr_tag;
   logic               lru_load;
   logic               lru_data;

`ifdef ICACHE_FILL_EARLY_RESTART_EN
   logic               early_valid;
   logic [31:0]        early_rdata;

   modport master (
      input  miss_req, miss_addr, miss_way, burst_resp, burst_rdata,
      output busy, fill_done, burst_read, burst_addr,
      output arr_load, arr_way, arr_windex, arr_line, arr_tag, lru_load, lru_data,
      output early_valid, early_rdata
   );

   modport slave (
      output miss_req, miss_addr, miss_way, burst_resp, burst_rdata,
      input  busy, fill_done, burst_read, burst_addr,
      input  arr_load, arr_way, arr_windex, arr_line, arr_tag, lru_load, lru_data,
      input  early_valid, early_rdata
   );
`else
   modport master (
      input  miss_req, miss_addr, miss_way, burst_resp, burst_rdata,
      output busy, fill_done, burst_read, burst_addr,
      output arr_load, arr_way, arr_windex, arr_line, arr_tag, lru_load, lru_data
   );

   modport slave (
      output miss_req, miss_addr, miss_way, burst_resp, burst_rdata,
      input  busy, fill_done, burst_read, burst_addr,
      input  arr_load, arr_way, arr_windex, arr_line, arr_tag, lru_load, lru_data
   );
`endif

endinterface

// File: rtl/icache_fill_ctrl.sv
// Miss handling and 4 x 64-bit line fill for the 2-way instruction cache.
// Optional critical-word early restart is built when ICACHE_FILL_EARLY_RESTART_EN is defined.
module icache_fill_ctrl #(
   parameter int unsigned s_index  = 5,
   parameter int unsigned s_offset = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   icache_fill_ctrl_if.master   fill
);

   localparam int unsigned s_tag   = 32 - s_index - s_offset;
   localparam int unsigned laddr_w = 32 - s_offset;
   localparam int unsigned beat_w  = 64;
   localparam int unsigned n_beats = 4;
   localparam int unsigned cnt_w   = 2;
   localparam int unsigned line_w  = beat_w * n_beats;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [cnt_w-1:0]     cnt_q, cnt_d;
   logic [line_w-1:0]    line_q, line_d;
   logic [laddr_w-1:0]   laddr_q, laddr_d;
   logic                 way_q, way_d;

   logic                 busy_q, busy_d;
   logic                 burst_read_q, burst_read_d;
   logic                 arr_load_q, arr_load_d;
   logic                 lru_load_q, lru_load_d;
   logic                 lru_data_q, lru_data_d;
   logic                 fill_done_q, fill_done_d;

`ifdef ICACHE_FILL_EARLY_RESTART_EN
   logic [cnt_w-1:0]     crit_beat_q, crit_beat_d;
   logic                 crit_word_q, crit_word_d;
   logic                 early_valid_q, early_valid_d;
   logic [31:0]          early_rdata_q, early_rdata_d;
`endif

   // State, buffer and output registers; reset drops any partial line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         line_q        <= '0;
         laddr_q       <= '0;
         way_q         <= 1'b0;
         busy_q        <= 1'b0;
         burst_read_q  <= 1'b0;
         arr_load_q    <= 1'b0;
         lru_load_q    <= 1'b0;
         lru_data_q    <= 1'b0;
         fill_done_q   <= 1'b0;
`ifdef ICACHE_FILL_EARLY_RESTART_EN
         crit_beat_q   <= '0;
         crit_word_q   <= 1'b0;
         early_valid_q <= 1'b0;
         early_rdata_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         line_q        <= line_d;
         laddr_q       <= laddr_d;
         way_q         <= way_d;
         busy_q        <= busy_d;
         burst_read_q  <= burst_read_d;
         arr_load_q    <= arr_load_d;
         lru_load_q    <= lru_load_d;
         lru_data_q    <= lru_data_d;
         fill_done_q   <= fill_done_d;
`ifdef ICACHE_FILL_EARLY_RESTART_EN
         crit_beat_q   <= crit_beat_d;
         crit_word_q   <= crit_word_d;
         early_valid_q <= early_valid_d;
         early_rdata_q <= early_rdata_d;
`endif
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      laddr_d     = laddr_q;
      way_d       = way_q;
      lru_data_d  = lru_data_q;
`ifdef ICACHE_FILL_EARLY_RESTART_EN
      crit_beat_d   = crit_beat_q;
      crit_word_d   = crit_word_q;
      early_valid_d = 1'b0;
      early_rdata_d = early_rdata_q;
`endif

      case (state_q)
         IDLE: begin
            if (fill.miss_req) begin
               laddr_d = fill.miss_addr[31:s_offset];
               way_d   = fill.miss_way;
`ifdef ICACHE_FILL_EARLY_RESTART_EN
               crit_beat_d = fill.miss_addr[4:3];
               crit_word_d = fill.miss_addr[2];
`endif
               state_d = REQ;
            end
         end
         REQ: begin
            if (fill.burst_resp) begin
               line_d[32'(cnt_q) * beat_w +: beat_w] = fill.burst_rdata;
               cnt_d = cnt_q + cnt_w'(1);
`ifdef ICACHE_FILL_EARLY_RESTART_EN
               if (cnt_q == crit_beat_q) begin
                  early_valid_d = 1'b1;
                  early_rdata_d = crit_word_q ? fill.burst_rdata[63:32]
                                              : fill.burst_rdata[31:0];
               end
`endif
               if (cnt_q == cnt_w'(n_beats - 1)) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes follow the state being entered so they are flop outputs.
      busy_d       = (state_d != IDLE);
      burst_read_d = (state_d == REQ);
      arr_load_d   = (state_d == WRITE);
      lru_load_d   = (state_d == WRITE);
      fill_done_d  = (state_d == DONE);
      if (state_d == WRITE) begin
         lru_data_d = ~way_q;
      end
   end

   assign fill.busy        = busy_q;
   assign fill.fill_done   = fill_done_q;
   assign fill.burst_read  = burst_read_q;
   assign fill.burst_addr  = {laddr_q, s_offset'(0)};
   assign fill.arr_load    = arr_load_q;
   assign fill.arr_way     = way_q;
   assign fill.arr_windex  = laddr_q[s_index-1:0];
   assign fill.arr_tag     = laddr_q[laddr_w-1:s_index];
   assign fill.arr_line    = line_q;
   assign fill.lru_load    = lru_load_q;
   assign fill.lru_data    = lru_data_q;
`ifdef ICACHE_FILL_EARLY_RESTART_EN
   assign fill.early_valid = early_valid_q;
   assign fill.early_rdata = early_rdata_q;
`endif

   logic unused_tag_w;
   assign unused_tag_w = (s_tag == 0);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Randomized self-checking bench for icache_fill_ctrl against a cycle-count model of a fill.
// Early-restart checks are included when ICACHE_FILL_EARLY_RESTART_EN is defined.
module tb_icache_fill_ctrl;

   localparam int unsigned s_index  = 5;
   localparam int unsigned s_offset = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   icache_fill_ctrl_if #(.s_index(s_index), .s_offset(s_offset)) bus ();

   icache_fill_ctrl #(.s_index(s_index), .s_offset(s_offset)) dut (
      .clk  (clk),
      .rst  (rst),
      .fill (bus)
   );

   int total = 0;
   int bad   = 0;

   // Observations gathered by do_fill
   int           r_load_cyc, r_done_cyc, r_nload, r_ndone, r_nburst, r_addr_bad, r_busy_bad;
   logic [255:0] r_line;
   logic [21:0]  r_tag;
   logic [4:0]   r_idx;
   logic         r_way, r_lru_load, r_lru_data;
   logic [31:0]  r_baddr;
   int           r_ecnt, r_ecyc;
   logic [31:0]  r_edata;

   // Reference model: address split and fill timing from plain arithmetic
   function automatic logic [31:0] m_line_addr(input logic [31:0] a);
      return (a / 32) * 32;
   endfunction
   function automatic logic [4:0] m_index(input logic [31:0] a);
      return 5'((a / 32) % 32);
   endfunction
   function automatic logic [21:0] m_tag(input logic [31:0] a);
      return 22'(a / 1024);
   endfunction
   function automatic int m_beat_cyc(input int k, input int gap);
      return 1 + k * (gap + 1);
   endfunction
   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [31:0] out_or();
      logic [31:0] v;
      v = {31'b0, bus.busy | bus.burst_read | bus.arr_load | bus.arr_way | bus.lru_load |
                  bus.lru_data | bus.fill_done | (|bus.burst_addr) | (|bus.arr_windex) |
                  (|bus.arr_line) | (|bus.arr_tag)};
`ifdef ICACHE_FILL_EARLY_RESTART_EN
      v = v | {31'b0, bus.early_valid | (|bus.early_rdata)};
`endif
      return v;
   endfunction

   // Drives one miss and a reactive memory; records what the DUT did, per cycle since miss_req.
   task automatic do_fill(input logic [31:0] addr, input logic way, input logic [255:0] line,
                          input int gap, input bit pester);
      int nb, wait_cnt, exp_done;
      bit prev_br, seen_addr;
      r_load_cyc = -1; r_done_cyc = -1; r_nload = 0; r_ndone = 0; r_nburst = 0;
      r_addr_bad = 0; r_busy_bad = 0; r_line = '0; r_tag = '0; r_idx = '0;
      r_way = 1'b0; r_lru_load = 1'b0; r_lru_data = 1'b0; r_baddr = '0;
      r_ecnt = 0; r_ecyc = -1; r_edata = '0;
      nb = 0; wait_cnt = 0; prev_br = 1'b0; seen_addr = 1'b0;
      exp_done = m_beat_cyc(3, gap) + 2;
      for (int c = 0; c <= exp_done + 3; c++) begin
         @(posedge clk); #1;
         if (bus.burst_read && !prev_br) r_nburst++;
         prev_br = bus.burst_read;
         if (bus.burst_read) begin
            if (!seen_addr) begin r_baddr = bus.burst_addr; seen_addr = 1'b1; end
            else if (bus.burst_addr !== r_baddr) r_addr_bad++;
         end
         if (bus.busy !== ((c >= 1) && (c <= exp_done))) r_busy_bad++;
         if (bus.arr_load) begin
            r_nload++; r_load_cyc = c; r_line = bus.arr_line; r_tag = bus.arr_tag;
            r_idx = bus.arr_windex; r_way = bus.arr_way; r_lru_load = bus.lru_load;
            r_lru_data = bus.lru_data;
         end
         if (bus.fill_done) begin r_ndone++; r_done_cyc = c; end
`ifdef ICACHE_FILL_EARLY_RESTART_EN
         if (bus.early_valid) begin r_ecnt++; r_ecyc = c; r_edata = bus.early_rdata; end
`endif
         bus.miss_req  = (c == 0) || (pester && ((c == 2) || bus.fill_done));
         bus.miss_addr = (c == 0) ? addr : (addr ^ 32'h0001_0040);
         bus.miss_way  = (c == 0) ? way : ~way;
         if (bus.burst_read && nb < 4 && wait_cnt == 0) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = line[64*nb +: 64];
            nb++;
            wait_cnt = gap;
         end else begin
            bus.burst_resp  = 1'b0;
            bus.burst_rdata = {$urandom, $urandom};
            if (bus.burst_read && wait_cnt > 0) wait_cnt--;
         end
      end
      @(posedge clk); #1;
      bus.miss_req = 1'b0; bus.burst_resp = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (out_or() !== 32'd0) begin
         bad++; $display("FAIL reset_outputs: got any-high=%0d need 0", out_or());
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_or() !== 32'd0) begin
         bad++; $display("FAIL post_reset_idle: got any-high=%0d need 0", out_or());
      end
   endtask

   task automatic test_zero_wait();
      logic [255:0] l;
      l = {64'h4, 64'h3, 64'h2, 64'h1};
      do_fill(32'h0000_1234, 1'b1, l, 0, 1'b0);
      total++; if (r_baddr !== 32'h0000_1220) begin bad++; $display("FAIL zw_burst_addr: got %h need 00001220", r_baddr); end
      total++; if (r_idx !== 5'h11) begin bad++; $display("FAIL zw_windex: got %h need 11", r_idx); end
      total++; if (r_tag !== 22'h4) begin bad++; $display("FAIL zw_tag: got %h need 4", r_tag); end
      total++; if (r_way !== 1'b1 || r_lru_data !== 1'b0 || r_lru_load !== 1'b1) begin
         bad++; $display("FAIL zw_way_lru: got way=%0b lru_load=%0b lru_data=%0b need 1 1 0", r_way, r_lru_load, r_lru_data); end
      total++; if (r_line !== l) begin bad++; $display("FAIL zw_line: got %h need %h", r_line, l); end
      total++; if (r_load_cyc != 5 || r_nload != 1) begin
         bad++; $display("FAIL zw_arr_load: got cycle %0d count %0d need cycle 5 count 1", r_load_cyc, r_nload); end
      total++; if (r_done_cyc != 6 || r_ndone != 1) begin
         bad++; $display("FAIL zw_fill_done: got cycle %0d count %0d need cycle 6 count 1", r_done_cyc, r_ndone); end
      total++; if (r_busy_bad != 0) begin bad++; $display("FAIL zw_busy: got %0d wrong cycles need 0", r_busy_bad); end
   endtask

   task automatic test_stalled();
      logic [255:0] l;
      l = {64'h4, 64'h3, 64'h2, 64'h1};
      do_fill(32'h0000_1234, 1'b1, l, 3, 1'b0);
      total++; if (r_nburst != 1 || r_addr_bad != 0 || r_baddr !== 32'h0000_1220) begin
         bad++; $display("FAIL stall_burst: got bursts=%0d addr_changes=%0d addr=%h need 1 0 00001220", r_nburst, r_addr_bad, r_baddr); end
      total++; if (r_line !== l) begin bad++; $display("FAIL stall_line: got %h need %h", r_line, l); end
      total++; if (r_load_cyc != m_beat_cyc(3, 3) + 1 || r_done_cyc != m_beat_cyc(3, 3) + 2) begin
         bad++; $display("FAIL stall_timing: got load %0d done %0d need %0d %0d", r_load_cyc, r_done_cyc, m_beat_cyc(3, 3) + 1, m_beat_cyc(3, 3) + 2); end
   endtask

   task automatic test_miss_while_busy();
      logic [255:0] l;
      l = rand_line();
      do_fill(32'h0000_4AC0, 1'b0, l, 1, 1'b1);
      total++; if (r_nburst != 1 || r_nload != 1 || r_ndone != 1) begin
         bad++; $display("FAIL busy_ignore: got bursts=%0d loads=%0d dones=%0d need 1 1 1", r_nburst, r_nload, r_ndone); end
      total++; if (r_line !== l || r_baddr !== 32'h0000_4AC0 || r_tag !== m_tag(32'h4AC0)) begin
         bad++; $display("FAIL busy_fill: got addr %h tag %h need %h %h", r_baddr, r_tag, 32'h4AC0, m_tag(32'h4AC0)); end
      total++; if (r_busy_bad != 0) begin bad++; $display("FAIL busy_level: got %0d wrong cycles need 0", r_busy_bad); end
   endtask

   task automatic test_stray_resp();
      logic [255:0] l;
      @(posedge clk); #1;
      bus.burst_resp = 1'b1; bus.burst_rdata = 64'hDEAD;
      @(posedge clk); #1;
      bus.burst_resp = 1'b0;
      total++; if (bus.busy !== 1'b0 || bus.burst_read !== 1'b0) begin
         bad++; $display("FAIL stray_state: got busy=%0b burst_read=%0b need 0 0", bus.busy, bus.burst_read); end
      l = rand_line();
      do_fill(32'h0000_8060, 1'b1, l, 0, 1'b0);
      total++; if (r_line !== l) begin bad++; $display("FAIL stray_line: got %h need %h", r_line, l); end
   endtask

   task automatic test_reset_mid_burst();
      logic [255:0] l;
      int loads;
      l = rand_line();
      @(posedge clk); #1;
      bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_3300; bus.miss_way = 1'b1;
      @(posedge clk); #1;
      bus.miss_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.burst_resp = 1'b1; bus.burst_rdata = l[64*k +: 64];
         @(posedge clk); #1;
      end
      bus.burst_resp = 1'b0;
      rst = 1'b1;
      #1;
      total++; if (out_or() !== 32'd0) begin bad++; $display("FAIL midrst_outputs: got any-high=%0d need 0", out_or()); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      loads = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.arr_load || bus.busy) loads++;
      end
      total++; if (loads != 0) begin bad++; $display("FAIL midrst_no_write: got %0d active cycles need 0", loads); end
      l = rand_line();
      do_fill(32'h0000_3300, 1'b0, l, 0, 1'b0);
      total++; if (r_line !== l || r_load_cyc != 5) begin
         bad++; $display("FAIL midrst_refill: got line %h load %0d need %h 5", r_line, r_load_cyc, l); end
   endtask

   task automatic test_random_fills();
      logic [255:0] l;
      logic [31:0]  a;
      logic         w;
      int           g;
      for (int n = 0; n < 8; n++) begin
         l = rand_line(); a = $urandom; w = 1'($urandom); g = int'($urandom_range(0, 3));
         do_fill(a, w, l, g, 1'($urandom));
         total++;
         if (r_line !== l || r_tag !== m_tag(a) || r_idx !== m_index(a) || r_way !== w ||
             r_lru_data !== ~w || r_baddr !== m_line_addr(a) || r_nburst != 1) begin
            bad++; $display("FAIL rand_fill%0d: got addr %h tag %h idx %h way %0b lru %0b need %h %h %h %0b %0b",
                            n, r_baddr, r_tag, r_idx, r_way, r_lru_data, m_line_addr(a), m_tag(a), m_index(a), w, ~w);
         end
         total++;
         if (r_load_cyc != m_beat_cyc(3, g) + 1 || r_done_cyc != m_beat_cyc(3, g) + 2 || r_busy_bad != 0) begin
            bad++; $display("FAIL rand_timing%0d: got load %0d done %0d busy_err %0d need %0d %0d 0",
                            n, r_load_cyc, r_done_cyc, r_busy_bad, m_beat_cyc(3, g) + 1, m_beat_cyc(3, g) + 2);
         end
`ifdef ICACHE_FILL_EARLY_RESTART_EN
         total++;
         if (r_ecnt != 1 || r_ecyc != m_beat_cyc(int'(a[4:3]), g) + 1 ||
             r_edata !== (a[2] ? l[64*a[4:3] + 32 +: 32] : l[64*a[4:3] +: 32])) begin
            bad++; $display("FAIL rand_early%0d: got count %0d cycle %0d data %h", n, r_ecnt, r_ecyc, r_edata);
         end
`endif
      end
   endtask

`ifdef ICACHE_FILL_EARLY_RESTART_EN
   task automatic test_early_restart();
      logic [255:0] l;
      l = {64'h4, 64'hAAAA_BBBB_CCCC_DDDD, 64'h2, 64'h1};
      do_fill(32'h0000_0014, 1'b0, l, 0, 1'b0);
      total++; if (r_ecnt != 1 || r_ecyc != 4) begin
         bad++; $display("FAIL early_valid: got count %0d cycle %0d need 1 4", r_ecnt, r_ecyc); end
      total++; if (r_edata !== 32'hAAAA_BBBB) begin bad++; $display("FAIL early_rdata: got %h need aaaabbbb", r_edata); end
      total++; if (r_line !== l) begin bad++; $display("FAIL early_line: got %h need %h", r_line, l); end
   endtask
`endif

   initial begin
      bus.miss_req = 1'b0; bus.miss_addr = '0; bus.miss_way = 1'b0;
      bus.burst_resp = 1'b0; bus.burst_rdata = '0;
      test_reset();
      test_zero_wait();
      test_stalled();
      test_miss_while_busy();
      test_stray_resp();
      test_reset_mid_burst();
`ifdef ICACHE_FILL_EARLY_RESTART_EN
      test_early_restart();
`endif
      test_random_fills();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
